// File: rtl/axi_ic_ar_if.sv
// AXI read-address channel bundle shared by the upstream and downstream sides of axi_ic_ar.
interface axi_ar_if #(
    parameter int AddrWidth = 32,
    parameter int IdWidth   = 8
) ();
    logic                 arvalid;
    logic                 arready;
    logic [AddrWidth-1:0] araddr;
    logic [IdWidth-1:0]   arid;
    logic [7:0]           arlen;
    logic [2:0]           arsize;
    logic [1:0]           arburst;
    logic                 arlock;
    logic [3:0]           arcache;
    logic [2:0]           arprot;

    modport master (output arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
                    input  arready);
    modport slave  (input  arvalid, araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot,
                    output arready);
endinterface

// File: rtl/axi_ic_ar.sv
// AR-channel crossbar: address decode, per-slave round-robin arbiter, 2-entry skid buffer per slave.
// Define AXI_IC_AR_ORDER_EN to enable the per-master outstanding-read ordering guard.
// Handshake: a transfer happens on a cycle where valid and ready are both high; valid and payload
// are held by the sender until that cycle, and ready may depend on valid combinationally.
module axi_ic_ar #(
    parameter int NumMasters   = 2,
    parameter int NumSlaves    = 2,
    parameter int AxiAddrWidth = 32,
    parameter int IdRWidth     = 8,
    parameter logic [AxiAddrWidth-1:0] SlaveBase [NumSlaves] = '{32'h0000_0000, 32'h1000_0000},
    parameter logic [AxiAddrWidth-1:0] SlaveMask [NumSlaves] = '{32'hF000_0000, 32'hF000_0000}
) (
    input  logic     aclk,
    input  logic     rst_n,
    axi_ar_if.slave  axi_sl_ar [NumMasters],
    axi_ar_if.master axi_m_ar  [NumSlaves],
    input  logic     r_done_i  [NumMasters]
);
    localparam int MstW   = (NumMasters > 1) ? $clog2(NumMasters) : 1;
    localparam int SlvW   = (NumSlaves > 1) ? $clog2(NumSlaves) : 1;
    localparam int HalfId = IdRWidth / 2;

    typedef struct packed {
        logic [AxiAddrWidth-1:0] addr;
        logic [IdRWidth-1:0]     id;
        logic [7:0]              len;
        logic [2:0]              size;
        logic [1:0]              burst;
        logic                    lock;
        logic [3:0]              cache;
        logic [2:0]              prot;
    } ar_t;

    logic            in_valid [NumMasters];
    ar_t             in_pay   [NumMasters];
    logic            in_ready [NumMasters];
    logic [SlvW-1:0] tgt      [NumMasters];
    logic            blocked  [NumMasters];

    logic [MstW-1:0] ptr_q [NumSlaves], ptr_d [NumSlaves];
    logic [MstW-1:0] win      [NumSlaves];
    logic            gnt_any  [NumSlaves];
    logic            push     [NumSlaves];
    ar_t             push_pay [NumSlaves];
    logic            sb_ready [NumSlaves];
    logic            m_ready  [NumSlaves];
    logic            out_v_q [NumSlaves], out_v_d [NumSlaves];
    logic            skid_v_q [NumSlaves], skid_v_d [NumSlaves];
    ar_t             out_q [NumSlaves], out_d [NumSlaves];
    ar_t             skid_q [NumSlaves], skid_d [NumSlaves];

    for (genvar i = 0; i < NumMasters; i++) begin : g_in
        // The master index occupies the upper half of the outgoing ID so R responses can be routed back.
        assign in_valid[i] = axi_sl_ar[i].arvalid;
        assign in_pay[i]   = {axi_sl_ar[i].araddr, HalfId'(i), axi_sl_ar[i].arid[HalfId-1:0],
                              axi_sl_ar[i].arlen, axi_sl_ar[i].arsize, axi_sl_ar[i].arburst,
                              axi_sl_ar[i].arlock, axi_sl_ar[i].arcache, axi_sl_ar[i].arprot};
        assign axi_sl_ar[i].arready = in_ready[i] & rst_n;
    end

    for (genvar j = 0; j < NumSlaves; j++) begin : g_out
        assign axi_m_ar[j].arvalid = out_v_q[j];
        assign axi_m_ar[j].araddr  = out_q[j].addr;
        assign axi_m_ar[j].arid    = out_q[j].id;
        assign axi_m_ar[j].arlen   = out_q[j].len;
        assign axi_m_ar[j].arsize  = out_q[j].size;
        assign axi_m_ar[j].arburst = out_q[j].burst;
        assign axi_m_ar[j].arlock  = out_q[j].lock;
        assign axi_m_ar[j].arcache = out_q[j].cache;
        assign axi_m_ar[j].arprot  = out_q[j].prot;
        assign m_ready[j]          = axi_m_ar[j].arready;
        assign sb_ready[j]         = !skid_v_q[j];
    end

    // Descending scan so the lowest matching slave wins; misses fall through to the last slave.
    always_comb begin
        for (int i = 0; i < NumMasters; i++) begin
            tgt[i] = SlvW'(NumSlaves - 1);
            for (int j = NumSlaves - 1; j >= 0; j--) begin
                if ((in_pay[i].addr & SlaveMask[j]) == SlaveBase[j]) tgt[i] = SlvW'(j);
            end
        end
    end

`ifdef AXI_IC_AR_ORDER_EN
    logic [3:0]      cnt_q  [NumMasters], cnt_d  [NumMasters];
    logic [SlvW-1:0] last_q [NumMasters], last_d [NumMasters];

    always_comb begin
        for (int i = 0; i < NumMasters; i++) begin
            blocked[i] = ((cnt_q[i] != 4'd0) && (tgt[i] != last_q[i])) || (cnt_q[i] == 4'd15);
        end
    end

    always_comb begin
        for (int i = 0; i < NumMasters; i++) begin
            cnt_d[i]  = cnt_q[i];
            last_d[i] = last_q[i];
            if (in_valid[i] && in_ready[i]) last_d[i] = tgt[i];
            if (in_valid[i] && in_ready[i] && !r_done_i[i]) cnt_d[i] = cnt_q[i] + 4'd1;
            else if (!(in_valid[i] && in_ready[i]) && r_done_i[i] && cnt_q[i] != 4'd0)
                cnt_d[i] = cnt_q[i] - 4'd1;
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NumMasters; i++) begin
                cnt_q[i]  <= '0;
                last_q[i] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end
`else
    logic unused_r_done;

    always_comb begin
        unused_r_done = 1'b0;
        for (int i = 0; i < NumMasters; i++) begin
            blocked[i]    = 1'b0;
            unused_r_done = unused_r_done | r_done_i[i];
        end
    end
`endif

    // Round-robin: scan from the pointer, first unblocked requester for this slave wins.
    always_comb begin
        int idx;
        idx = 0;
        for (int j = 0; j < NumSlaves; j++) begin
            gnt_any[j] = 1'b0;
            win[j]     = '0;
            for (int k = 0; k < NumMasters; k++) begin
                idx = int'(ptr_q[j]) + k;
                if (idx >= NumMasters) idx = idx - NumMasters;
                if (!gnt_any[j] && in_valid[idx] && !blocked[idx] && (tgt[idx] == SlvW'(j))) begin
                    gnt_any[j] = 1'b1;
                    win[j]     = MstW'(idx);
                end
            end
            push[j]     = gnt_any[j] & sb_ready[j];
            push_pay[j] = in_pay[win[j]];
        end
    end

    always_comb begin
        for (int i = 0; i < NumMasters; i++) begin
            in_ready[i] = 1'b0;
            for (int j = 0; j < NumSlaves; j++) begin
                if (push[j] && (win[j] == MstW'(i))) in_ready[i] = 1'b1;
            end
        end
    end

    // Skid buffer: out_q drives the slave, skid_q catches one beat while out_q is stalled.
    always_comb begin
        logic pop;
        pop = 1'b0;
        for (int j = 0; j < NumSlaves; j++) begin
            ptr_d[j]    = ptr_q[j];
            out_v_d[j]  = out_v_q[j];
            out_d[j]    = out_q[j];
            skid_v_d[j] = skid_v_q[j];
            skid_d[j]   = skid_q[j];
            pop         = out_v_q[j] & m_ready[j];
            if (push[j]) ptr_d[j] = (win[j] == MstW'(NumMasters - 1)) ? '0 : win[j] + 1'b1;
            if (!out_v_q[j] || pop) begin
                if (skid_v_q[j]) begin
                    out_d[j]    = skid_q[j];
                    out_v_d[j]  = 1'b1;
                    skid_v_d[j] = 1'b0;
                end else begin
                    out_v_d[j] = push[j];
                    if (push[j]) out_d[j] = push_pay[j];
                end
            end else if (push[j]) begin
                skid_v_d[j] = 1'b1;
                skid_d[j]   = push_pay[j];
            end
        end
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NumSlaves; j++) begin
                ptr_q[j]    <= '0;
                out_v_q[j]  <= 1'b0;
                skid_v_q[j] <= 1'b0;
                out_q[j]    <= '0;
                skid_q[j]   <= '0;
            end
        end else begin
            ptr_q    <= ptr_d;
            out_v_q  <= out_v_d;
            skid_v_q <= skid_v_d;
            out_q    <= out_d;
            skid_q   <= skid_d;
        end
    end
endmodule
